// File: rtl/dram_ser_pkg.sv
// Shared definitions for the DRAM serializer pair (PISO here, SIPO downstream).
package dram_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DRAM_SER_WIDTH = 8;

    // Bit-counter width for a given word width; the SIPO sizes its counter the same way.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/dram_piso_if.sv
// Word handshake in, serial bit stream out, for the PISO stage.
interface dram_piso_if
    import dram_ser_pkg::*;
#(
    parameter int WIDTH = DRAM_SER_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, frame_done, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, frame_done, busy
    );
endinterface

// File: rtl/dram_piso.sv
// Parallel-in serial-out stage: one word per handshake, shifted out MSB first.
// A word offered on the last bit of a frame is taken immediately, so frames
// run back to back with ser_valid held high.
//
//  state | meaning
//  IDLE  | no frame, in_ready high, ser_out parked at IDLE_BIT
//  SHIFT | driving shreg MSB each cycle; cnt = index of the bit on the wire
module dram_piso
    import dram_ser_pkg::*;
#(
    parameter int   WIDTH    = DRAM_SER_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic       clk,
    input logic       rst_b,
    dram_piso_if.slave bus
);
    localparam int            CW      = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [0:0]    S_IDLE  = 1'(IDLE);
    localparam logic [0:0]    S_SHIFT = 1'(SHIFT);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             shifting;
    logic             last_bit;
    logic             ready;
    logic             accept;

    // Explicit compare against WIDTH-1 so non-power-of-2 widths never rely on wrap.
    assign shifting = (state == S_SHIFT);
    assign last_bit = shifting && (cnt == LAST);
    assign ready    = (state == S_IDLE) || last_bit;
    assign accept   = bus.in_valid && ready;

    // State, shifter and bit counter; a load on the last bit restarts the frame in place.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= S_SHIFT;
            shreg <= bus.in_data;
            cnt   <= '0;
        end else if (last_bit) begin
            state <= S_IDLE;
            shreg <= shreg << 1;
            cnt   <= '0;
        end else if (shifting) begin
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        bus.in_ready   = ready;
        bus.ser_out    = shifting ? shreg[WIDTH-1] : IDLE_BIT;
        bus.ser_valid  = shifting;
        bus.frame_done = last_bit;
        bus.busy       = shifting;
    end
endmodule

// File: tb/tb_dram_piso.sv
// Bench for dram_piso: bit-queue reference model on a WIDTH=8 and a WIDTH=5
// instance, plus directed frames with literal expectations.
module tb_dram_piso;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dram_piso_if #(.WIDTH(8)) a8 ();
    dram_piso_if #(.WIDTH(5)) a5 ();

    dram_piso #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (.clk(clk), .rst_b(rst_b), .bus(a8.slave));
    dram_piso #(.WIDTH(5), .IDLE_BIT(1'b0)) u5 (.clk(clk), .rst_b(rst_b), .bus(a5.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of bits still owed on the wire.
    bit q8[$];
    bit q5[$];

    always @(posedge clk or negedge rst_b) begin
        bit acc;
        if (!rst_b) begin
            q8.delete();
            q5.delete();
        end else begin
            acc = a8.in_valid && (q8.size() <= 1);
            if (q8.size() > 0) void'(q8.pop_front());
            if (acc) for (int i = 7; i >= 0; i--) q8.push_back(a8.in_data[i]);
            acc = a5.in_valid && (q5.size() <= 1);
            if (q5.size() > 0) void'(q5.pop_front());
            if (acc) for (int i = 4; i >= 0; i--) q5.push_back(a5.in_data[i]);
        end
    end

    // Downstream SIPO as the receiver would build it.
    logic [7:0] sipo8 = '0;
    always @(posedge clk) if (a8.ser_valid) sipo8 <= {sipo8[6:0], a8.ser_out};

    always @(negedge clk) begin
        check("m8_ser_valid", a8.ser_valid, q8.size() > 0);
        check("m8_ser_out", a8.ser_out, (q8.size() > 0) ? q8[0] : 1'b0);
        check("m8_frame_done", a8.frame_done, q8.size() == 1);
        check("m8_busy", a8.busy, q8.size() > 0);
        check("m8_in_ready", a8.in_ready, q8.size() <= 1);
        check("m5_ser_valid", a5.ser_valid, q5.size() > 0);
        check("m5_ser_out", a5.ser_out, (q5.size() > 0) ? q5[0] : 1'b0);
        check("m5_frame_done", a5.frame_done, q5.size() == 1);
        check("m5_busy", a5.busy, q5.size() > 0);
        check("m5_in_ready", a5.in_ready, q5.size() <= 1);
    end

    task automatic send8(input logic [7:0] w);
        int n = 0;
        @(negedge clk); #1;
        a8.in_valid = 1'b1;
        a8.in_data  = w;
        while (!a8.in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept8_wait", n < 100, 1'b1);
        @(posedge clk); #1;
        a8.in_valid = 1'b0;
        a8.in_data  = 8'($urandom);
    endtask

    task automatic grab8(input int n, output logic [15:0] bits, output logic [15:0] fd,
                         output logic [15:0] rdy, output int nvalid);
        bits = '0; fd = '0; rdy = '0; nvalid = 0;
        repeat (n) begin
            @(negedge clk);
            if (a8.ser_valid) begin
                bits = {bits[14:0], a8.ser_out};
                nvalid++;
            end
            fd  = {fd[14:0], a8.frame_done};
            rdy = {rdy[14:0], a8.in_ready};
        end
    endtask

    initial begin
        logic [15:0] bits, fd, rdy;
        logic [4:0]  bits5, fd5;
        int          nv, fdseen;

        a8.in_valid = 1'b0; a8.in_data = '0;
        a5.in_valid = 1'b0; a5.in_data = '0;
        repeat (3) @(negedge clk);
        #1 rst_b = 1'b1;

        // Idle after reset
        repeat (5) begin
            @(negedge clk);
            check("idle_ser_valid", a8.ser_valid, 1'b0);
            check("idle_ser_out", a8.ser_out, 1'b0);
            check("idle_in_ready", a8.in_ready, 1'b1);
            check("idle_busy", a8.busy, 1'b0);
        end

        // Single frame 0xA5
        send8(8'hA5);
        grab8(8, bits, fd, rdy, nv);
        check("a5_bits", bits[7:0], 8'hA5);
        check("a5_nvalid", nv, 8);
        check("a5_frame_done", fd[7:0], 8'b0000_0001);
        check("a5_in_ready", rdy[7:0], 8'b0000_0001);
        @(negedge clk);
        check("a5_back_idle", a8.ser_valid, 1'b0);
        check("a5_sipo", sipo8, 8'hA5);

        // Back-to-back 0x3C then 0xC3
        @(negedge clk); #1;
        a8.in_valid = 1'b1;
        a8.in_data  = 8'h3C;
        @(posedge clk); #1;
        a8.in_data = 8'hC3;
        bits = '0; fd = '0; nv = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (a8.ser_valid) begin
                bits = {bits[14:0], a8.ser_out};
                nv++;
            end
            fd = {fd[14:0], a8.frame_done};
            if (i == 7) begin
                @(posedge clk); #1;
                a8.in_valid = 1'b0;
            end
        end
        check("b2b_bits", bits, 16'h3CC3);
        check("b2b_nvalid", nv, 16);
        check("b2b_frame_done", fd, 16'h0101);

        // Reset during bit 4 of 0xFF
        send8(8'hFF);
        grab8(3, bits, fd, rdy, nv);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        check("rst_ser_valid", a8.ser_valid, 1'b0);
        check("rst_ser_out", a8.ser_out, 1'b0);
        check("rst_frame_done", a8.frame_done, 1'b0);
        check("rst_busy", a8.busy, 1'b0);
        check("rst_in_ready", a8.in_ready, 1'b1);
        fdseen = 0;
        repeat (3) begin
            @(negedge clk);
            fdseen += int'(a8.frame_done);
        end
        #1 rst_b = 1'b1;
        @(negedge clk);
        fdseen += int'(a8.frame_done);
        check("rst_no_frame_done", fdseen, 0);
        send8(8'h81);
        grab8(8, bits, fd, rdy, nv);
        check("post_rst_bits", bits[7:0], 8'h81);
        check("post_rst_frame_done", fd[7:0], 8'b0000_0001);

        // WIDTH=5 frame with in_data churning mid-frame
        @(negedge clk); #1;
        a5.in_valid = 1'b1;
        a5.in_data  = 5'b10011;
        @(posedge clk); #1;
        a5.in_valid = 1'b0;
        bits5 = '0; fd5 = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bits5 = {bits5[3:0], a5.ser_out};
            fd5   = {fd5[3:0], a5.frame_done};
            #1 a5.in_data = 5'($urandom);
        end
        check("w5_bits", bits5, 5'b10011);
        check("w5_frame_done", fd5, 5'b00001);
        @(negedge clk);
        check("w5_back_idle", a5.ser_valid, 1'b0);

        // Random traffic on both instances, one reset pulse in the middle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            a8.in_valid = ($urandom_range(0, 3) != 0);
            a8.in_data  = 8'($urandom);
            a5.in_valid = ($urandom_range(0, 3) != 0);
            a5.in_data  = 5'($urandom);
            if (i == 1500) begin
                #1 rst_b = 1'b0;
                @(negedge clk);
                #1 rst_b = 1'b1;
            end
        end
        @(negedge clk); #1;
        a8.in_valid = 1'b0;
        a5.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("end_idle8", a8.busy, 1'b0);
        check("end_idle5", a5.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
